// File: rtl/d_lsu_sequencer.sv
// d_lsu_sequencer
//   Multi-cycle sequencer for D-format loads and stores. It latches the
//   instruction fields at start, forms the effective address
//   Rn + sext(imm9), and then owns the RAM and register-file write controls
//   until done. Loads can be byte/half/word/double, sign- or zero-extended.
//   Stores narrower than DATA_WIDTH use a read-modify-write cycle.
//
//   Instruction layout: I = {op[10:0], imm9, op2, Rn, Rt}
//     op[10:9] access size, op[2] signed load, op[1] load
//
//   Ports
//     clock, reset_n       rising-edge clock, asynchronous active-low reset
//     start, I             one-cycle request and instruction (taken only when idle)
//     rf_a_data/rf_b_data  Rn / Rt contents, held valid while busy
//     rf_sa/rf_sb/rf_da    register-file read selects and write destination
//     rf_w, rf_wdata       register write strobe and extended load data
//     mem_addr, mem_we,
//     mem_wdata, mem_rdata RAM word port (read data MEM_LATENCY cycles after addr)
//     busy, done, fault    not-idle flag, completion pulse, abort flag with done
//
//   Optional feature macro: ALIGN_CHECK_EN
//     defined   : an access misaligned for its size finishes at once with fault=1
//     undefined : the low address bits are cleared to the access size; fault=0
module d_lsu_sequencer #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned RAM_ADDR_WIDTH = 16,
   parameter int unsigned MEM_LATENCY    = 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [31:0]               I,
   input  logic [DATA_WIDTH-1:0]     rf_a_data,
   input  logic [DATA_WIDTH-1:0]     rf_b_data,
   output logic [4:0]                rf_sa,
   output logic [4:0]                rf_sb,
   output logic [4:0]                rf_da,
   output logic                      rf_w,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
   output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_we,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      fault
);

   localparam int unsigned LANE_W   = $clog2(DATA_WIDTH / 8);
   localparam logic [1:0]  MAX_SIZE = 2'(LANE_W);
   localparam logic [1:0]  LAT_INIT = 2'(MEM_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_READ, S_MERGE, S_WRITE, S_WB, S_FIN
   } state_t;

   // Low (8 << sz) bits set; all ones for a full-width access.
   function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] sz);
      logic [DATA_WIDTH-1:0] m;
      if (sz >= MAX_SIZE) m = '1;
      else                m = (DATA_WIDTH'(1) << (32'd8 << sz)) - DATA_WIDTH'(1);
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [DATA_WIDTH-1:0] word,
      input logic [LANE_W-1:0]     lane,
      input logic [1:0]            sz,
      input logic                  sgn
   );
      logic [DATA_WIDTH-1:0] m;
      logic [DATA_WIDTH-1:0] sh;
      logic                  neg;
      m   = size_mask(sz);
      sh  = (word >> {lane, 3'b000}) & m;
      // m ^ (m >> 1) isolates the most significant bit of the lane: its sign.
      neg = sgn && ((sh & (m ^ (m >> 1))) != '0);
      return neg ? (sh | ~m) : sh;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] store_merge(
      input logic [DATA_WIDTH-1:0] word,
      input logic [DATA_WIDTH-1:0] src,
      input logic [LANE_W-1:0]     lane,
      input logic [1:0]            sz
   );
      logic [DATA_WIDTH-1:0] m;
      m = size_mask(sz) << {lane, 3'b000};
      return (word & ~m) | ((src << {lane, 3'b000}) & m);
   endfunction

   state_t                    state_q, state_d;
   logic [1:0]                size_q, size_d;
   logic                      is_load_q, is_load_d;
   logic                      is_signed_q, is_signed_d;
   logic [8:0]                imm_q, imm_d;
   logic [4:0]                rf_sa_q, rf_sa_d;
   logic [4:0]                rf_sb_q, rf_sb_d;
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic [1:0]                cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic [RAM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                      mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
   logic                      rf_w_q, rf_w_d;
   logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      fault_q, fault_d;

   logic [DATA_WIDTH-1:0]     ea;
   logic [LANE_W-1:0]         align_m;
   logic                      unused_op;

   assign ea        = rf_a_data + {{(DATA_WIDTH-9){imm_q[8]}}, imm_q};
   assign align_m   = LANE_W'((32'd1 << size_q) - 32'd1);
   assign unused_op = ^{I[29:24], I[21], I[11:10]};

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      is_load_d   = is_load_q;
      is_signed_d = is_signed_q;
      imm_d       = imm_q;
      rf_sa_d     = rf_sa_q;
      rf_sb_d     = rf_sb_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rf_wdata_d  = rf_wdata_q;
      fault_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               size_d      = (I[31:30] > MAX_SIZE) ? MAX_SIZE : I[31:30];
               is_signed_d = I[23];
               is_load_d   = I[22];
               imm_d       = I[20:12];
               rf_sa_d     = I[9:5];
               rf_sb_d     = I[4:0];
               state_d     = S_ADDR;
            end
         end
         S_ADDR: begin
            mem_addr_d = RAM_ADDR_WIDTH'(ea >> LANE_W);
            lane_d     = ea[LANE_W-1:0] & ~align_m;
`ifdef ALIGN_CHECK_EN
            if ((ea[LANE_W-1:0] & align_m) != '0) begin
               fault_d = 1'b1;
               state_d = S_FIN;
            end else
`endif
            if (!is_load_q && (size_q == MAX_SIZE)) begin
               mem_wdata_d = rf_b_data;
               state_d     = S_WRITE;
            end else begin
               cnt_d   = LAT_INIT;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (cnt_q == 2'd0) begin
               data_d = mem_rdata;
               if (is_load_q) begin
                  rf_wdata_d = load_extend(mem_rdata, lane_q, size_q, is_signed_q);
                  state_d    = S_WB;
               end else begin
                  state_d    = S_MERGE;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_MERGE: begin
            mem_wdata_d = store_merge(data_q, rf_b_data, lane_q, size_q);
            state_d     = S_WRITE;
         end
         S_WRITE: state_d = S_FIN;
         S_WB:    state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Strobes are registered from the next state so they line up with it.
      mem_we_d = (state_d == S_WRITE);
      rf_w_d   = (state_d == S_WB);
      done_d   = (state_d == S_FIN);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         size_q      <= '0;
         is_load_q   <= 1'b0;
         is_signed_q <= 1'b0;
         imm_q       <= '0;
         rf_sa_q     <= '0;
         rf_sb_q     <= '0;
         lane_q      <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rf_w_q      <= 1'b0;
         rf_wdata_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         is_load_q   <= is_load_d;
         is_signed_q <= is_signed_d;
         imm_q       <= imm_d;
         rf_sa_q     <= rf_sa_d;
         rf_sb_q     <= rf_sb_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         rf_w_q      <= rf_w_d;
         rf_wdata_q  <= rf_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
      end
   end

   assign rf_sa     = rf_sa_q;
   assign rf_sb     = rf_sb_q;
   assign rf_da     = rf_sb_q;
   assign rf_w      = rf_w_q;
   assign rf_wdata  = rf_wdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_d_lsu_sequencer.sv
module tb_d_lsu_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        start3 = 1'b0;
   logic [31:0] I = '0;
   logic [63:0] rf_a_data = '0;
   logic [63:0] rf_b_data = '0;

   logic [4:0]  rf_sa, rf_sb, rf_da;
   logic        rf_w, mem_we, busy, done, fault;
   logic [63:0] rf_wdata, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;

   logic [4:0]  rf_sa3, rf_sb3, rf_da3;
   logic        rf_w3, mem_we3, busy3, done3, fault3;
   logic [63:0] rf_wdata3, mem_wdata3, mem_rdata3;
   logic [15:0] mem_addr3;

   logic [63:0] ram  [0:65535];
   logic [63:0] mref [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [63:0] pre_data = '0;
   logic [63:0] p1, p2;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   logic [63:0] last_rf = '0;

   always #5 clock = ~clock;

   d_lsu_sequencer #(.DATA_WIDTH(64), .RAM_ADDR_WIDTH(16), .MEM_LATENCY(1)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .I(I),
      .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
      .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_da(rf_da), .rf_w(rf_w), .rf_wdata(rf_wdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .fault(fault)
   );

   d_lsu_sequencer #(.DATA_WIDTH(64), .RAM_ADDR_WIDTH(16), .MEM_LATENCY(3)) dut3 (
      .clock(clock), .reset_n(reset_n), .start(start3), .I(I),
      .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
      .rf_sa(rf_sa3), .rf_sb(rf_sb3), .rf_da(rf_da3), .rf_w(rf_w3), .rf_wdata(rf_wdata3),
      .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
      .busy(busy3), .done(done3), .fault(fault3)
   );

   // RAM: combinational read for the latency-1 port, two extra stages for latency 3
   assign mem_rdata = ram[mem_addr];
   always @(posedge clock) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      p1 <= ram[mem_addr3];
      p2 <= p1;
   end
   assign mem_rdata3 = p2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [1:0] sz, input bit ld, input bit sg,
                                      input logic [8:0] imm, input logic [4:0] rn,
                                      input logic [4:0] rt);
      return {sz, 6'b0, sg, ld, 1'b0, imm, 2'b00, rn, rt};
   endfunction

   // Reference memory viewed as a flat byte array (little-endian within a word).
   function automatic logic [7:0] ref_byte(input logic [63:0] a);
      logic [63:0] w;
      w = mref[a[18:3]];
      return w[8*a[2:0] +: 8];
   endfunction

   function automatic void ref_wbyte(input logic [63:0] a, input logic [7:0] d);
      logic [63:0] w;
      w = mref[a[18:3]];
      w[8*a[2:0] +: 8] = d;
      mref[a[18:3]] = w;
   endfunction

   function automatic logic [63:0] ref_load(input logic [31:0] ins, input logic [63:0] rn);
      int unsigned nb;
      logic [63:0] ea, ea_al, val;
      logic [8:0]  imm;
      nb    = 1 << ins[31:30];
      imm   = ins[20:12];
      ea    = rn + {{55{imm[8]}}, imm};
      ea_al = ea - (ea % nb);
      val   = '0;
      for (int b = 0; b < nb; b++) val = val | (64'(ref_byte(ea_al + 64'(b))) << (8 * b));
      if (ins[23] && nb < 8 && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
      return val;
   endfunction

   task automatic preload(input logic [15:0] a, input logic [63:0] d);
      @(negedge clock);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clock);
      pre_we = 1'b0;
      mref[a] = d;
   endtask

   task automatic run_op(input logic [31:0] ins, input logic [63:0] rn,
                         input logic [63:0] rt, input bit poke);
      int unsigned nb, exp_lat, edges, n_we, n_rfw, n_ovl;
      logic [63:0] ea, ea_al, val, got_rf;
      logic [15:0] wi, got_addr;
      logic [8:0]  imm;
      logic [4:0]  got_da;
      bit          ld, abort, got_fault;
      ld    = ins[22];
      nb    = 1 << ins[31:30];
      imm   = ins[20:12];
      ea    = rn + {{55{imm[8]}}, imm};
      ea_al = ea - (ea % nb);
      wi    = ea_al[18:3];
      val   = '0;
      abort = 1'b0;
`ifdef ALIGN_CHECK_EN
      abort = ((ea % nb) != 0);
`endif
      if (abort) exp_lat = 3;
      else if (ld) begin
         val     = ref_load(ins, rn);
         exp_lat = 5;
      end else begin
         for (int b = 0; b < nb; b++) ref_wbyte(ea_al + 64'(b), rt[8*b +: 8]);
         exp_lat = (nb == 8) ? 4 : 6;
      end

      @(negedge clock);
      I = ins; rf_a_data = rn; rf_b_data = rt; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      edges = 1; n_we = 0; n_rfw = 0; n_ovl = 0;
      got_rf = '0; got_addr = '0; got_da = '0;
      while (!done && edges < 40) begin
         if (mem_we) begin n_we++; got_addr = mem_addr; end
         if (rf_w) begin n_rfw++; got_rf = rf_wdata; got_da = rf_da; end
         if (mem_we && rf_w) n_ovl++;
         start = poke && (edges == 2);
         if (poke && edges == 2) I = ~ins;
         @(negedge clock);
         edges++;
      end
      start = 1'b0;
      got_fault = fault;
      if (mem_we || rf_w) n_ovl++;
      chk("latency", 64'(edges + 1), 64'(exp_lat));
      chk("strobe_overlap", 64'(n_ovl), 64'd0);
      chk("fault", 64'(got_fault), 64'(abort));
      chk("rf_sa", 64'(rf_sa), 64'(ins[9:5]));
      chk("we_count", 64'(n_we), (!ld && !abort) ? 64'd1 : 64'd0);
      chk("rfw_count", 64'(n_rfw), (ld && !abort) ? 64'd1 : 64'd0);
      if (ld && !abort) begin
         chk("rf_wdata", got_rf, val);
         chk("rf_da", 64'(got_da), 64'(ins[4:0]));
      end
      if (!ld && !abort) chk("mem_addr", 64'(got_addr), 64'(wi));
      chk("ram_word", ram[wi], mref[wi]);
      last_rf = got_rf;
      @(negedge clock);
      chk("busy_after", 64'(busy), 64'd0);
   endtask

   task automatic run_ld3(input logic [31:0] ins, input logic [63:0] rn);
      int unsigned edges;
      logic [63:0] got;
      @(negedge clock);
      I = ins; rf_a_data = rn; start3 = 1'b1;
      @(negedge clock);
      start3 = 1'b0;
      edges = 1; got = '0;
      while (!done3 && edges < 40) begin
         if (rf_w3) got = rf_wdata3;
         @(negedge clock);
         edges++;
      end
      chk("lat3_latency", 64'(edges + 1), 64'd7);
      chk("lat3_rf_wdata", got, ref_load(ins, rn));
   endtask

   initial begin
      logic [63:0] tgt, rn;
      logic [8:0]  imm;

      // Reset state
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_rf_w", 64'(rf_w), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      for (int w = 32'h20; w < 32'h40; w++) preload(16'(w), {$urandom, $urandom});
      @(negedge clock);
      reset_n = 1'b1;

      // Full-width store: ea 0x108 -> word 0x21
      run_op(mk(2'd3, 1'b0, 1'b0, 9'd8, 5'd1, 5'd2), 64'h100, 64'hDEADBEEFCAFEF00D, 1'b0);
      chk("tp_full_store", ram[16'h21], 64'hDEADBEEFCAFEF00D);

      // Word loads from ea 0x104-4 = 0x100
      preload(16'h20, 64'h0000000080000001);
      run_op(mk(2'd2, 1'b1, 1'b1, 9'h1FC, 5'd4, 5'd5), 64'h104, 64'h0, 1'b0);
      chk("tp_lw_signed", last_rf, 64'hFFFFFFFF80000001);
      run_op(mk(2'd2, 1'b1, 1'b0, 9'h1FC, 5'd4, 5'd6), 64'h104, 64'h0, 1'b0);
      chk("tp_lw_unsigned", last_rf, 64'h0000000080000001);

      // Byte store RMW at ea 0x103
      preload(16'h20, 64'h1122334455667788);
      run_op(mk(2'd0, 1'b0, 1'b0, 9'd3, 5'd7, 5'd8), 64'h100, 64'h00000000000055AB, 1'b0);
      chk("tp_byte_rmw", ram[16'h20], 64'h11223344AB667788);

      // Misaligned half store at ea 0x107
      run_op(mk(2'd1, 1'b0, 1'b0, 9'd7, 5'd7, 5'd9), 64'h100, 64'h000000001234BEEF, 1'b0);
`ifdef ALIGN_CHECK_EN
      chk("tp_misaligned_half", ram[16'h20], 64'h11223344AB667788);
`else
      chk("tp_misaligned_half", ram[16'h20], 64'hBEEF3344AB667788);
`endif

      // start pulsed while busy must be ignored
      run_op(mk(2'd1, 1'b1, 1'b1, 9'h1F0, 5'd3, 5'd10), 64'h130, 64'h0, 1'b1);
      run_op(mk(2'd0, 1'b0, 1'b0, 9'd1, 5'd3, 5'd11), 64'h140, 64'h77, 1'b1);

      // Load into XZR still pulses rf_w
      run_op(mk(2'd3, 1'b1, 1'b0, 9'd0, 5'd3, 5'd31), 64'h128, 64'h0, 1'b0);

      // Reset during READ of a sub-width store
      @(negedge clock);
      I = mk(2'd1, 1'b0, 1'b0, 9'd0, 5'd1, 5'd2); rf_a_data = 64'h120;
      rf_b_data = 64'hFFFF; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("midrst_busy_before", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_mem_we", 64'(mem_we), 64'd0);
      @(negedge clock);
      chk("midrst_mem_we_hold", 64'(mem_we), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      chk("midrst_ram", ram[16'h24], mref[16'h24]);
      run_op(mk(2'd1, 1'b0, 1'b0, 9'd0, 5'd1, 5'd2), 64'h120, 64'h4321, 1'b0);

      // Randomized accesses inside the preloaded window, high Rn bits exercise truncation
      repeat (48) begin
         imm = 9'($urandom);
         tgt = 64'($urandom_range(32'h100, 32'h1FF));
         rn  = tgt - {{55{imm[8]}}, imm} + ({32'h0, $urandom} << 19);
         run_op(mk(2'($urandom), 1'($urandom), 1'($urandom), imm, 5'($urandom), 5'($urandom)),
                rn, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
      end

      // MEM_LATENCY = 3 instance
      run_ld3(mk(2'd2, 1'b1, 1'b1, 9'd0, 5'd1, 5'd2), 64'h138);
      run_ld3(mk(2'd0, 1'b1, 1'b1, 9'h1FF, 5'd1, 5'd3), 64'h15A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/d_lsu_sequencer.md
Name: d_lsu_sequencer

Overview:
- Multi-cycle sequencer for D-format loads and stores. It is the next generation of the combinational D-format decoder.
- Adds byte, half, word and double access sizes, sign-extended imm9 offsets, sign/zero-extended loads and read-modify-write for sub-width stores.
- Sits between the control unit's instruction register, the register file read ports and the data RAM. It owns RAM and RF-write control for the duration of one D-format instruction.

Parameters:
DATA_WIDTH, 64, register/RAM word width in bits; must be a power of two, 16 to 64
RAM_ADDR_WIDTH, 16, RAM word-address width
MEM_LATENCY, 1, cycles from mem_addr valid to mem_rdata valid; range 1 to 4

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; I is a D-format instruction; ignored unless busy=0
I  in  32  instruction {op[10:0], imm9, op2, Rn, Rt}
rf_a_data  in  DATA_WIDTH  contents of Rn, valid while busy
rf_b_data  in  DATA_WIDTH  contents of Rt (store data), valid while busy
rf_sa  out  5  Rn, latched at start
rf_sb  out  5  Rt, latched at start
rf_da  out  5  Rt destination
rf_w  out  1  register write strobe
rf_wdata  out  DATA_WIDTH  extended load result
mem_addr  out  RAM_ADDR_WIDTH  RAM word address
mem_we  out  1  RAM write strobe
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data
busy  out  1  sequencer not IDLE
done  out  1  one-cycle completion pulse
fault  out  1  valid with done; access aborted

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE. All outputs 0. Internal registers cleared. Reset mid-operation abandons the access with no RF or RAM write.
- Decode at start, latched into internal registers:
  - size = op[10:9]: 00 byte, 01 half, 10 word, 11 double. Size capped at log2(DATA_WIDTH/8).
  - is_load = op[1].
  - is_signed = op[2] (LDURSW-style). Zero-extend otherwise.
- Effective address: ea = rf_a_data + sign_extend(imm9), computed in ADDR, modulo 2^DATA_WIDTH.
  - mem_addr = ea >> log2(DATA_WIDTH/8), truncated to RAM_ADDR_WIDTH.
  - lane = ea low bits, forced down to size alignment (low bits cleared) unless ALIGN_CHECK_EN is defined.
- States:
  - IDLE: start -> ADDR.
  - ADDR: latch ea. Full-width store -> WRITE. Otherwise -> READ.
  - READ: drive mem_addr. Wait MEM_LATENCY cycles, then capture mem_rdata.
    - Load -> WB.
    - Store -> MERGE.
  - MERGE: replace the size-wide lane of the captured word with the low bits of rf_b_data -> WRITE.
  - WRITE: mem_we=1 for exactly one cycle. Full-width store writes rf_b_data directly -> FIN.
  - WB: rf_w=1 for one cycle. rf_wdata = lane, sign- or zero-extended to DATA_WIDTH -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Latency, MEM_LATENCY=1:
  - Full-width store: 4 cycles from start to done.
  - Load: 5 cycles.
  - Sub-width store: 6 cycles.
- Rt=31 load: rf_w still pulses. The register file discards writes to XZR.
- start while busy=1 is ignored. There is no queueing.
- Outputs are registered. rf_w, mem_we and done are never asserted together.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: ea not aligned to the access size -> ADDR goes directly to FIN with fault=1. No RAM write, no RF write.
- Undefined: low bits are silently cleared (forced alignment). fault is tied to 0.

Test Plan:
- Full-width store, DATA_WIDTH=64: Rn=0x100, imm9=+8, Rt=0xDEADBEEFCAFEF00D -> mem_we at cycle 3, mem_addr=0x21, mem_wdata=Rt, done at cycle 4.
- Signed word load: RAM[0x20]=0x00000000_8000_0001, Rn=0x104, imm9=-4 -> ea=0x100, rf_wdata=0xFFFFFFFF80000001 when op[2]=1, 0x0000000080000001 when op[2]=0.
- Byte store RMW: RAM[0x20]=0x1122334455667788, ea=0x103, Rt low byte=0xAB -> RAM[0x20]=0x11223344AB667788.
- Misaligned half at ea=0x107:
  - With ALIGN_CHECK_EN: done with fault=1, no mem_we.
  - Without: lane 6, RMW on bytes 6-7.
- Reset mid-operation: reset_n=0 during READ of a store -> busy=0, no mem_we. A subsequent start completes normally.
- start asserted while busy -> ignored. MEM_LATENCY=3 extends load latency to 7 cycles.
